// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and constants for uart_tx_arb (TAG states exist only with UART_TX_ARB_ID_PREFIX_EN)
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
`ifdef UART_TX_ARB_ID_PREFIX_EN
    S_TAG,
    S_TAG_WAIT,
`endif
    S_LOAD,
    S_WAIT,
    S_ACK
  } state_t;
  localparam logic [2:0] BAUD_RST = 3'd4;
  localparam logic [7:0] ID_BASE_DEFAULT = 8'hA0;
  function automatic logic [7:0] tag_byte(logic [7:0] base, logic [7:0] idx);
    return base | idx;
  endfunction
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester, configuration and transmitter signals of uart_tx_arb
interface uart_tx_arb_if #(parameter int NUM_REQ = 4);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] ack;
  logic [2:0] cfg_baud_set;
  logic [7:0] data_byte;
  logic send_en;
  logic [2:0] baud_set;
  logic tx_done;
  logic uart_state;
  logic busy;
  logic [IW-1:0] grant_id;
  modport master (
    input req, req_data, cfg_baud_set, tx_done, uart_state,
    output ack, data_byte, send_en, baud_set, busy, grant_id
  );
  modport slave (
    output req, req_data, cfg_baud_set, tx_done, uart_state,
    input ack, data_byte, send_en, baud_set, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 modulo NUM_REQ
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               vld
);
  // walk offsets from farthest to nearest so the nearest pending requester wins
  always_comb begin
    logic [IW-1:0] c;
    c = '0;
    idx = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = IW'((int'(last) + k) % NUM_REQ);
      idx = req[c] ? c : idx;
    end
    vld = |req;
    gnt = vld ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_byte_tx among NUM_REQ requesters; UART_TX_ARB_ID_PREFIX_EN sends a tag byte before each payload
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter logic [7:0] ID_BASE = ID_BASE_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  uart_tx_arb_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic tx_done_q, tx_rise, gnt_vld;
  logic [NUM_REQ-1:0] gnt, gnt_q;
  logic [IW-1:0] gnt_idx;
  logic [7:0] gnt_byte;
`ifdef UART_TX_ARB_ID_PREFIX_EN
  logic [7:0] payload;
`endif
  if (NUM_REQ < 2 || NUM_REQ > 8 || (ID_BASE & 8'((1 << IW) - 1)) != 8'h00) begin : g_bad_cfg
    $error("uart_tx_arb: NUM_REQ must be 2..8 and ID_BASE must leave the index bits clear");
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(bus.req), .last(bus.grant_id), .gnt(gnt), .idx(gnt_idx), .vld(gnt_vld)
  );
  assign gnt_byte = bus.req_data[8*gnt_idx +: 8];
  assign tx_rise = bus.tx_done & ~tx_done_q;
  // registered copy of tx_done for rising-edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tx_done_q <= 1'b0;
    else tx_done_q <= bus.tx_done;
  // grant, optional tag, payload launch, completion wait and ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      bus.data_byte <= 8'h00;
      bus.send_en <= 1'b0;
      bus.ack <= '0;
      bus.busy <= 1'b0;
      bus.baud_set <= BAUD_RST;
      bus.grant_id <= IW'(NUM_REQ - 1);
      gnt_q <= '0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
      payload <= 8'h00;
`endif
    end else begin
      bus.send_en <= 1'b0;
      bus.ack <= '0;
      case (state)
        S_IDLE: if (gnt_vld && !bus.uart_state) begin
          bus.baud_set <= bus.cfg_baud_set;
          bus.grant_id <= gnt_idx;
          gnt_q <= gnt;
          bus.busy <= 1'b1;
          bus.send_en <= 1'b1;
`ifdef UART_TX_ARB_ID_PREFIX_EN
          payload <= gnt_byte;
          bus.data_byte <= tag_byte(ID_BASE, 8'(gnt_idx));
          state <= S_TAG;
`else
          bus.data_byte <= gnt_byte;
          state <= S_LOAD;
`endif
        end
`ifdef UART_TX_ARB_ID_PREFIX_EN
        S_TAG: state <= S_TAG_WAIT;
        S_TAG_WAIT: if (tx_rise) begin
          bus.data_byte <= payload;
          bus.send_en <= 1'b1;
          state <= S_LOAD;
        end
`endif
        S_LOAD: state <= S_WAIT;
        S_WAIT: if (tx_rise) begin
          bus.ack <= gnt_q;
          state <= S_ACK;
        end
        S_ACK: begin
          bus.busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: random and directed bench for uart_tx_arb against a transfer-level model; honours UART_TX_ARB_ID_PREFIX_EN
module tb_uart_tx_arb;
  import uart_pkg::*;
  localparam int N = 4;
  localparam int BIT = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic force_busy = 1'b0;
  logic tx_busy, tx_done_r;
  int tx_cnt;
  logic [7:0] tx_byte;
  logic [7:0] q[N][$];
  int checks = 0, errors = 0;
  int obs_f[$], obs_a[$];
  int send_cnt = 0;
  int exp_frames[$];
  int exp_ack = -1;
  int last = N - 1;
  int pay_byte, xfer_byte, xfer_baud;
  bit ack_due, tag_due, live, rst_seen;
  logic [N-1:0] req_prev;
  logic [8*N-1:0] data_prev;
  logic [2:0] cfg_prev;
  logic ust_prev, busy_prev, ack_prev;
  int ef[$], ea[$];

  uart_tx_arb_if #(.NUM_REQ(N)) bus();
  uart_tx_arb #(.NUM_REQ(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #10 clk = ~clk;

  // transmitter stand-in: 10 bit times per frame, done pulse as busy drops
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_busy <= 1'b0; tx_done_r <= 1'b0; tx_cnt <= 0; tx_byte <= 8'h00;
    end else begin
      tx_done_r <= 1'b0;
      if (!tx_busy) begin
        if (bus.send_en) begin tx_busy <= 1'b1; tx_byte <= bus.data_byte; tx_cnt <= 0; end
      end else if (tx_cnt == 10*BIT-1) begin
        tx_busy <= 1'b0; tx_done_r <= 1'b1;
      end else tx_cnt <= tx_cnt + 1;
    end
  assign bus.tx_done = tx_done_r;
  assign bus.uart_state = tx_busy | force_busy;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic chk_list(input string n, input int got[$], input int exp[$]);
    chk({n, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(n, got[i], exp[i]);
  endtask

  function automatic int rr(logic [N-1:0] r, int l);
    for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // one live cycle of the transfer-level model
  task automatic step();
    bit nack = 1'b0, ntag = 1'b0, go;
    int w;
    chk("ack_onehot", int'($onehot0(bus.ack)), 1);
    if (ack_due) begin
      chk("ack", bus.ack, 1 << exp_ack);
      obs_a.push_back(int'(bus.ack));
      exp_ack = -1;
    end else chk("no_ack", bus.ack, 0);
    if (!busy_prev) begin
      go = (req_prev != 0) && !ust_prev;
      chk("idle_send", bus.send_en, go);
      chk("idle_busy", bus.busy, go);
      if (go) begin
        w = rr(req_prev, last);
        last = w;
        exp_ack = w;
        xfer_baud = cfg_prev;
        pay_byte = data_prev[8*w +: 8];
`ifdef UART_TX_ARB_ID_PREFIX_EN
        xfer_byte = ID_BASE_DEFAULT | w;
        exp_frames.push_back(xfer_byte);
`else
        xfer_byte = pay_byte;
`endif
        exp_frames.push_back(pay_byte);
        chk("grant_id", bus.grant_id, w);
        chk("grant_baud", bus.baud_set, xfer_baud);
        chk("grant_data", bus.data_byte, xfer_byte);
      end
    end else begin
      chk("busy_send", bus.send_en, tag_due);
      if (tag_due) xfer_byte = pay_byte;
      chk("busy", bus.busy, !ack_prev);
      chk("hold_data", bus.data_byte, xfer_byte);
      chk("hold_baud", bus.baud_set, xfer_baud);
      chk("hold_gid", bus.grant_id, last);
    end
    if (bus.send_en) send_cnt++;
    if (tx_done_r) begin
      obs_f.push_back(int'(tx_byte));
      chk("frame_pending", int'(exp_frames.size() > 0), 1);
      if (exp_frames.size() > 0) begin
        chk("frame", tx_byte, exp_frames.pop_front());
        if (exp_frames.size() == 0) nack = 1'b1; else ntag = 1'b1;
      end
    end
    ack_due = nack;
    tag_due = ntag;
  endtask

  // compare process, sampling on the falling edge
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      if (!rst_seen) begin
        chk("rst_send", bus.send_en, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_baud", bus.baud_set, 4);
        chk("rst_data", bus.data_byte, 0);
        chk("rst_gid", bus.grant_id, N - 1);
      end
      rst_seen = 1'b1; live = 1'b0; exp_frames.delete(); exp_ack = -1;
      ack_due = 1'b0; tag_due = 1'b0; last = N - 1;
    end else begin
      rst_seen = 1'b0;
      if (live) step();
      live = 1'b1;
    end
    req_prev = bus.req; data_prev = bus.req_data; cfg_prev = bus.cfg_baud_set;
    ust_prev = bus.uart_state; busy_prev = bus.busy; ack_prev = |bus.ack;
  end

  // requester agents: hold the head byte until its ack
  initial begin
    logic [N-1:0] r;
    logic [8*N-1:0] d;
    bus.req = '0;
    bus.req_data = '0;
    forever begin
      @(posedge clk); #1;
      r = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0) begin r[i] = 1'b1; d[8*i +: 8] = q[i][0]; end
      end
      bus.req = r;
      bus.req_data = d;
    end
  end

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (all_empty() && !bus.busy && exp_ack < 0) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic wait_send(input int budget);
    int s = send_cnt;
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (send_cnt > s) begin ok = 1'b1; break; end
    end
    chk("send_timeout", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    obs_f.delete(); obs_a.delete();
  endtask

  initial begin
    int s0;
    bus.cfg_baud_set = 3'd4;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    // single request
    q[0].push_back(8'hAA);
    wait_idle(500);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    ef = '{8'hA0, 8'hAA};
`else
    ef = '{8'hAA};
`endif
    ea = '{1};
    chk_list("single_frames", obs_f, ef);
    chk_list("single_acks", obs_a, ea);
    chk("single_busy_after", bus.busy, 0);
    // all requesting after reset
    do_reset();
    q[0].push_back(8'h11); q[1].push_back(8'h22); q[2].push_back(8'h33); q[3].push_back(8'h44);
    wait_idle(2000);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    ef = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33, 8'hA3, 8'h44};
`else
    ef = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    ea = '{1, 2, 4, 8};
    chk_list("all_frames", obs_f, ef);
    chk_list("all_acks", obs_a, ea);
    // fairness against a requester that stays high
    do_reset();
    q[0].push_back(8'h55); q[0].push_back(8'h55);
    wait_send(50);
    repeat (5) @(posedge clk);
    #1 q[2].push_back(8'h77);
    wait_idle(2000);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    ef = '{8'hA0, 8'h55, 8'hA2, 8'h77, 8'hA0, 8'h55};
`else
    ef = '{8'h55, 8'h77, 8'h55};
`endif
    ea = '{1, 4, 1};
    chk_list("fair_frames", obs_f, ef);
    chk_list("fair_acks", obs_a, ea);
    // transmitter reported busy
    do_reset();
    force_busy = 1'b1;
    s0 = send_cnt;
    q[1].push_back(8'h66);
    repeat (20) @(posedge clk);
    #1 chk("busy_hold_send", send_cnt - s0, 0);
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("busy_release", send_cnt - s0, 1);
    wait_idle(1000);
    ea = '{2};
    chk_list("busy_acks", obs_a, ea);
    // reset in the middle of a frame
    do_reset();
    q[0].push_back(8'h3C);
    wait_send(50);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    obs_f.delete(); obs_a.delete();
    wait_idle(1000);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    ef = '{8'hA0, 8'h3C};
`else
    ef = '{8'h3C};
`endif
    ea = '{1};
    chk_list("rst_frames", obs_f, ef);
    chk_list("rst_acks", obs_a, ea);
    // request dropped mid-transfer still completes
    obs_f.delete(); obs_a.delete();
    q[1].push_back(8'h99);
    wait_send(50);
    repeat (3) @(posedge clk);
    #1 q[1].delete();
    wait_idle(1000);
    ea = '{2};
    chk_list("drop_acks", obs_a, ea);
    // tag prefix case
    obs_f.delete(); obs_a.delete();
    q[2].push_back(8'h5A);
    wait_idle(1000);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    ef = '{8'hA2, 8'h5A};
`else
    ef = '{8'h5A};
`endif
    ea = '{4};
    chk_list("tag_frames", obs_f, ef);
    chk_list("tag_acks", obs_a, ea);
    // random traffic with baud changes, busy glitches and one reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int i;
      @(posedge clk); #1;
      if (cyc == 1500) reset_n = 1'b0;
      if (cyc == 1502) reset_n = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        i = $urandom_range(0, N - 1);
        if (q[i].size() < 3) q[i].push_back(8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 199) == 0) bus.cfg_baud_set = 3'($urandom_range(0, 7));
      force_busy = ($urandom_range(0, 39) == 0);
    end
    force_busy = 1'b0;
    wait_idle(5000);
    chk("final_frames", exp_frames.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one uart_byte_tx; legal range is 2..8.
REQ-002 Parameter ID_BASE, default 8'hA0, is the base value of the tag byte; tag = ID_BASE | grant index.
REQ-003 Ports:
  clk  in  1  sole clock.
  reset_n  in  1  asynchronous, active-low reset.
  req  in  NUM_REQ  per-requester byte-pending level.
  req_data  in  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i].
  ack  out  NUM_REQ  one-cycle pulse to requester i when its byte has finished.
  cfg_baud_set  in  3  baud code requested by software.
  data_byte  out  8  byte to the transmitter.
  send_en  out  1  one-cycle start pulse to the transmitter.
  baud_set  out  3  baud code to the transmitter.
  tx_done  in  1  transmitter completion pulse.
  uart_state  in  1  transmitter busy level.
  busy  out  1  high in every state except IDLE.
  grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.

Function
REQ-004 FSM states: IDLE, TAG, TAG_WAIT, LOAD, WAIT, ACK; TAG and TAG_WAIT exist only under REQ-015.
REQ-005 IDLE: if any req bit is set and uart_state=0, the FSM grants round-robin, searching from grant_id+1 modulo NUM_REQ upward.
REQ-006 IDLE with no req, or with uart_state=1: the FSM stays in IDLE and send_en stays 0.
REQ-007 On grant: the FSM latches req_data slice into data_byte, latches cfg_baud_set into baud_set, updates grant_id, and goes to LOAD (or TAG under REQ-015).
REQ-008 LOAD: send_en=1 for exactly one cycle, then the FSM goes to WAIT; this gives one cycle from grant to send_en.
REQ-009 WAIT: the FSM holds data_byte and baud_set stable and waits for tx_done rising (edge-detected on a registered copy); tx_done before LOAD is ignored.
REQ-010 ACK: ack[grant_id]=1 for one cycle, then the FSM returns to IDLE; at most one ack bit is ever set.
REQ-011 Requesters hold req and req_data until ack; if req drops mid-transfer, the byte still completes and ack still pulses.
REQ-012 A requester re-requesting right after its ack is served only after every other pending requester (fairness bound NUM_REQ-1 transfers).
REQ-013 cfg_baud_set changes are sampled only at grant; a change mid-transfer takes effect on the next grant.

Reset
REQ-014 While reset_n=0:
  - FSM = IDLE.
  - data_byte = 8'h00, send_en = 0, ack = 0, busy = 0.
  - baud_set = 3'd4.
  - grant_id = NUM_REQ-1, so requester 0 has first priority after reset.
  - tx_done edge register = 0.
  Reset asserted mid-transfer aborts with no ack.

Configuration
REQ-015 UART_TX_ARB_ID_PREFIX_EN defined:
  - After grant, TAG drives data_byte = ID_BASE | grant_id with a one-cycle send_en.
  - TAG_WAIT waits for tx_done, then the FSM loads the payload and goes to LOAD.
  - ack is issued after the payload only.
  Undefined: TAG and TAG_WAIT are absent and each grant sends the payload byte only.

Structure
REQ-016 Shared package uart_pkg holds:
  - state encoding typedef;
  - BAUD_RST = 3'd4;
  - ID_BASE default.
REQ-017 One sub-module, rr_arbiter: NUM_REQ request vector plus last-grant input produce a one-hot grant and a grant index, purely combinational.
REQ-018 The FSM, latches and edge detector stay in uart_tx_arb.

Verification
REQ-019 The bench instantiates uart_tx_arb with a real uart_byte_tx, 50 MHz clock, cfg_baud_set=4.
REQ-020 Single request: req=4'b0001, req_data[7:0]=8'hAA -> send_en one cycle later, data_byte=8'hAA; uart_tx frames 0xAA; ack=4'b0001 after tx_done; busy low afterwards.
REQ-021 All requesting after reset: req=4'b1111, bytes 11/22/33/44 -> serial order 11,22,33,44; acks 0001,0010,0100,1000, one per frame.
REQ-022 Fairness: req[0] held high with data 55, req[2] pulsed during the first frame -> order 55, req2 byte, 55.
REQ-023 Busy transmitter: uart_state forced 1 while req=4'b0010 -> no send_en until uart_state=0, then a grant within 1 cycle.
REQ-024 Reset mid-frame: reset_n low during WAIT -> send_en=0, ack=0, baud_set=4, busy=0; after release, a pending req=4'b0001 is re-granted and completes.
REQ-025 With UART_TX_ARB_ID_PREFIX_EN, req=4'b0100 data 8'h5A -> frames A2 then 5A; a single ack 4'b0100 after the second tx_done.
